// File: rtl/crc_wr_sequencer_if.sv
// Handshake and datapath bundle between the write data block, the CRC generator and the
// DQ serializer. The optional i_err_inj member exists only when CRC_SEQ_ERR_INJ_EN is defined.
interface crc_wr_sequencer_if #(
  parameter int N = 16
);
  localparam int W = 2 * N;

  // Beats move on i_wr_valid & o_wr_ready at a rising edge; a source that has raised
  // i_wr_valid holds it and i_wr_data stable until that edge.
  logic           i_wr_valid;
  logic [W-1:0]   i_wr_data;
  logic           o_wr_ready;
  logic           i_crc_mode;
  logic           o_crc_en;
  logic [W-1:0]   o_crc_data;
  logic [W-1:0]   i_crc_code;
  logic           o_dq_valid;
  logic [W-1:0]   o_dq_data;
  logic           o_dq_crc;
  logic           o_busy;
  logic [1:0]     dbg_state;
`ifdef CRC_SEQ_ERR_INJ_EN
  logic           i_err_inj;
`endif

  modport master (
`ifdef CRC_SEQ_ERR_INJ_EN
    input  i_err_inj,
`endif
    input  i_wr_valid, i_wr_data, i_crc_mode, i_crc_code,
    output o_wr_ready, o_crc_en, o_crc_data, o_dq_valid, o_dq_data, o_dq_crc, o_busy,
    output dbg_state
  );

  modport slave (
`ifdef CRC_SEQ_ERR_INJ_EN
    output i_err_inj,
`endif
    output i_wr_valid, i_wr_data, i_crc_mode, i_crc_code,
    input  o_wr_ready, o_crc_en, o_crc_data, o_dq_valid, o_dq_data, o_dq_crc, o_busy,
    input  dbg_state
  );
endinterface

// File: rtl/crc_wr_sequencer.sv
// Sequences one DDR5 write burst through the write-CRC generator and appends the CRC beat.
// Optional feature: define CRC_SEQ_ERR_INJ_EN to allow inverting bit 0 of the CRC beat.
module crc_wr_sequencer #(
  parameter int N     = 16,
  parameter int BEATS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  crc_wr_sequencer_if.master   bus
);
  localparam int W = 2 * N;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [2:0]   beat_cnt, beat_cnt_nxt;
  logic         crc_on, crc_on_nxt;
  logic         accept;
  logic         crc_mode_eff;
  logic         last_beat;
  logic [W-1:0] crc_capture;
  logic         dq_valid_q, dq_crc_q;
  logic [W-1:0] dq_data_q;

  assign bus.o_wr_ready = (state != FLUSH);
  assign accept         = bus.i_wr_valid & bus.o_wr_ready;
  assign last_beat      = (beat_cnt == 3'(BEATS - 1));

  // The mode is only live on beat 0; later beats use the value latched at that point.
  assign crc_mode_eff   = (state == IDLE) ? bus.i_crc_mode : crc_on;
  assign bus.o_crc_en   = (accept & crc_mode_eff) | (state == FLUSH);
  assign bus.o_crc_data = bus.i_wr_data;
  assign bus.o_busy     = (beat_cnt != 3'd0) | (state == FLUSH);
  assign bus.dbg_state  = state;

`ifdef CRC_SEQ_ERR_INJ_EN
  assign crc_capture = bus.i_crc_code ^ {{(W-1){1'b0}}, bus.i_err_inj};
`else
  assign crc_capture = bus.i_crc_code;
`endif

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    crc_on_nxt   = crc_on;
    case (state)
      IDLE: begin
        if (accept) begin
          crc_on_nxt   = bus.i_crc_mode;
          beat_cnt_nxt = 3'd1;
          state_nxt    = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          if (last_beat) begin
            beat_cnt_nxt = 3'd0;
            state_nxt    = crc_on ? FLUSH : IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt + 3'd1;
          end
        end
      end
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      beat_cnt <= 3'd0;
      crc_on   <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      crc_on   <= crc_on_nxt;
    end
  end

  // The generator presents its code only during FLUSH, so that is the one cycle to capture it.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      dq_valid_q <= 1'b0;
      dq_data_q  <= '0;
      dq_crc_q   <= 1'b0;
    end else if (accept) begin
      dq_valid_q <= 1'b1;
      dq_data_q  <= bus.i_wr_data;
      dq_crc_q   <= 1'b0;
    end else if (state == FLUSH) begin
      dq_valid_q <= 1'b1;
      dq_data_q  <= crc_capture;
      dq_crc_q   <= 1'b1;
    end else begin
      dq_valid_q <= 1'b0;
      dq_crc_q   <= 1'b0;
    end
  end

  assign bus.o_dq_valid = dq_valid_q;
  assign bus.o_dq_data  = dq_data_q;
  assign bus.o_dq_crc   = dq_crc_q;
endmodule

// File: doc/crc_wr_sequencer.md
# crc_wr_sequencer

Controller that sequences the write-CRC datapath for one DDR5 write burst. It accepts 2N-bit write-data beats from the write data block, forwards them to the DQ serializer, drives the enable of the CRC generator for exactly the cycles that generator needs, captures the finished CRC code and appends it as the final beat of the burst. It sits between the write data block and the CRC generator/serializer, and is instantiated once per device width N.

## Interface
- N, 16, device width (4, 8, 16); all data buses are 2N bits
- BEATS, 8, data beats per burst; fixed by the CRC generator's 8-cycle accumulation

- i_clk  in  1  clock; all logic rises on posedge
- i_reset  in  1  asynchronous active-low reset
- i_wr_valid  in  1  write beat offered
- i_wr_data  in  2N  write beat payload
- o_wr_ready  out  1  beat accepted when i_wr_valid & o_wr_ready
- i_crc_mode  in  1  write-CRC enabled (mode register); sampled on beat 0 acceptance only
- o_crc_en  out  1  enable to CRC generator (combinational)
- o_crc_data  out  2N  data to CRC generator (equals i_wr_data)
- i_crc_code  in  2N  CRC generator output; nonzero only in its 9th enabled cycle
- o_dq_valid  out  1  registered output beat valid
- o_dq_data  out  2N  registered output beat
- o_dq_crc  out  1  current output beat is the CRC beat
- o_busy  out  1  burst in progress (beat_cnt != 0 or FLUSH)

## Operation
- States: IDLE, DATA, FLUSH. Registers: beat_cnt (3 bits), crc_on (latched mode), output regs.
- IDLE: o_wr_ready=1. On accept: latch crc_on<=i_crc_mode, beat_cnt<=1, go DATA.
- DATA: o_wr_ready=1. Each accept increments beat_cnt. On accept with beat_cnt==7: beat_cnt<=0, go FLUSH if crc_on else IDLE.
- FLUSH: o_wr_ready=0, lasts exactly 1 cycle; o_crc_en=1 so generator clears its counter; i_crc_code captured into o_dq_data with o_dq_crc=1; next state IDLE.
- o_crc_en = (accept & crc_mode_eff) | (state==FLUSH), where crc_mode_eff is i_crc_mode in IDLE, crc_on in DATA. Never asserted on non-accepting cycles, so generator counter holds during stalls.
- Every accepted beat is registered to o_dq_data with o_dq_valid=1, o_dq_crc=0 next cycle.
- Stall (i_wr_valid low) mid-burst: state and beat_cnt hold, o_dq_valid=0 that cycle.
- i_crc_mode changes mid-burst are ignored until next beat 0.

## Timing
- Reset: state=IDLE, beat_cnt=0, crc_on=0, o_dq_valid=0, o_dq_data=0, o_dq_crc=0, o_busy=0; o_wr_ready=1, o_crc_en=0 after reset release.
- Latency: accepted beat → o_dq_data 1 cycle. Unstalled CRC burst: accepts at cycles 0–7, data out 1–8, FLUSH at 8, CRC beat out at 9.
- Back-to-back: new beat 0 accepted at cycle 9 (IDLE); output stream contiguous, 9 beats per 10 cycles with CRC, 8 per 8 without.
- Reset asserted mid-burst: all state cleared immediately; partial burst discarded; CRC generator shares i_reset so it is cleared too.

## Configuration
- CRC_SEQ_ERR_INJ_EN: when defined, adds input i_err_inj (1 bit); if high during FLUSH, bit 0 of the captured CRC beat is inverted (for DRAM CRC-error alert testing). When undefined, port absent and CRC passes unmodified.

## Test plan
- Reset, then 8 unstalled beats 0x01..0x08 with i_crc_mode=1 → o_crc_en high cycles 0–8, o_dq_data 0x01..0x08 at cycles 1–8, CRC beat with o_dq_crc=1 at cycle 9 equal to generator reference.
- Same burst with i_crc_mode=0 → o_crc_en never high, 8 output beats, no CRC beat, o_wr_ready never drops.
- i_wr_valid low for 3 cycles after beat 4 → o_crc_en low those 3 cycles, CRC beat unchanged versus unstalled run.
- Two back-to-back CRC bursts → o_wr_ready low only in each FLUSH cycle; second burst's beat 0 appears cycle 10, its CRC independent of first burst.
- i_reset asserted after beat 5 then released, new full burst → o_busy 0 during reset, new CRC matches reference (no residue).
- With CRC_SEQ_ERR_INJ_EN, i_err_inj=1 in FLUSH → CRC beat equals reference XOR 1.
